// File: rtl/mult_job_scheduler.sv
// Host-bus job sequencer for the 24x24 multiply/popcount datapath: queues operand
// pairs, issues them one at a time over start/done, and buffers results for readback.
module mult_job_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  output logic        dp_start,
  output logic [23:0] dp_a1,
  output logic [23:0] dp_a2,
  input  logic        dp_busy,
  input  logic        dp_done,
  input  logic [31:0] dp_w,
  input  logic [23:0] dp_l,
  input  logic        dp_valid,
  output logic [15:0] job_count,
  output logic        irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [15:0] ADDR_A1  = 16'h0380;
  localparam logic [15:0] ADDR_A2  = 16'h0388;
  localparam logic [15:0] ADDR_W   = 16'h0390;
  localparam logic [15:0] ADDR_L   = 16'h0398;
  localparam logic [15:0] ADDR_CTL = 16'h03A0;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_STORE} state_t;

  state_t      state_q, state_d;
  logic        swr_q, swr_d, srd_q, srd_d;
  logic [23:0] a1_q, a1_d, a2_q, a2_d;
  logic [AW:0] jwp_q, jwp_d, jrp_q, jrp_d;
  logic [AW:0] rwp_q, rwp_d, rrp_q, rrp_d;
  logic [31:0] sdata_out_q, sdata_out_d;
  logic        dp_start_q, dp_start_d;
  logic [23:0] dp_a1_q, dp_a1_d, dp_a2_q, dp_a2_d;
  logic [15:0] job_count_q, job_count_d;
  logic        ovf_q, ovf_d, unf_q, unf_d, tmo_q, tmo_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  // Result entry layout: {timed_out, valid, L[23:0], W[31:0]}
  logic [57:0] hold_q, hold_d;

  logic [47:0] job_mem [DEPTH];
  logic [57:0] res_mem [DEPTH];

  logic        wr_edge, rd_edge;
  logic        job_push, job_pop, res_push, res_pop;
  logic [AW:0] job_level, res_level;
  logic        job_empty, job_full, res_empty, res_full;
  logic [47:0] job_head;
  logic [57:0] res_head;
  logic [31:0] status;
  logic        unused_sdata;

  assign unused_sdata = ^sdata_in[30:24];

  assign wr_edge   = swr & ~swr_q;
  assign rd_edge   = srd & ~srd_q;
  assign job_level = jwp_q - jrp_q;
  assign res_level = rwp_q - rrp_q;
  assign job_empty = (job_level == '0);
  assign res_empty = (res_level == '0);
  assign job_full  = (job_level == (AW+1)'(DEPTH));
  assign res_full  = (res_level == (AW+1)'(DEPTH));
  assign job_head  = job_mem[jrp_q[AW-1:0]];
  assign res_head  = res_empty ? 58'h0 : res_mem[rrp_q[AW-1:0]];

  assign status = {14'h0, res_head[57], res_head[56], 4'(res_level), 4'(job_level),
                   2'b00, tmo_q, unf_q, ovf_q, ~res_empty, job_full, (state_q != S_IDLE)};

  always_comb begin
    state_d     = state_q;
    swr_d       = swr;
    srd_d       = srd;
    a1_d        = a1_q;
    a2_d        = a2_q;
    jwp_d       = jwp_q;
    jrp_d       = jrp_q;
    rwp_d       = rwp_q;
    rrp_d       = rrp_q;
    sdata_out_d = sdata_out_q;
    dp_start_d  = 1'b0;
    dp_a1_d     = dp_a1_q;
    dp_a2_d     = dp_a2_q;
    job_count_d = job_count_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    tmo_d       = tmo_q;
    wait_cnt_d  = wait_cnt_q;
    hold_d      = hold_q;
    job_push    = 1'b0;
    job_pop     = 1'b0;
    res_push    = 1'b0;
    res_pop     = 1'b0;

    if (wr_edge) begin
      case (saddress)
        ADDR_A1: a1_d = sdata_in[23:0];
        ADDR_A2: a2_d = sdata_in[23:0];
        ADDR_CTL: begin
          if (sdata_in[31]) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
            tmo_d = 1'b0;
          end else if (job_full) begin
            ovf_d = 1'b1;
          end else begin
            job_push = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Status is built from registered state, so a same-cycle write is not visible yet
    if (rd_edge) begin
      case (saddress)
        ADDR_W: begin
          if (res_empty) begin
            sdata_out_d = 32'h0;
            unf_d       = 1'b1;
          end else begin
            sdata_out_d = res_head[31:0];
            res_pop     = 1'b1;
          end
        end
        ADDR_L:   sdata_out_d = {8'h0, res_head[55:32]};
        ADDR_CTL: sdata_out_d = status;
        default:  sdata_out_d = 32'h0;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (!job_empty && !res_full && !dp_busy) begin
          state_d    = S_ISSUE;
          dp_start_d = 1'b1;
          dp_a1_d    = job_head[47:24];
          dp_a2_d    = job_head[23:0];
          job_pop    = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d    = S_WAIT;
        wait_cnt_d = '0;
      end
      S_WAIT: begin
        if (dp_done) begin
          hold_d  = {1'b0, dp_valid, dp_l, dp_w};
          state_d = S_STORE;
        end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
          hold_d  = {1'b1, 57'h0};
          tmo_d   = 1'b1;
          state_d = S_STORE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_STORE: begin
        res_push    = 1'b1;
        job_count_d = job_count_q + 16'd1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (job_push) jwp_d = jwp_q + 1'b1;
    if (job_pop)  jrp_d = jrp_q + 1'b1;
    if (res_push) rwp_d = rwp_q + 1'b1;
    if (res_pop)  rrp_d = rrp_q + 1'b1;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      swr_q       <= 1'b0;
      srd_q       <= 1'b0;
      a1_q        <= '0;
      a2_q        <= '0;
      jwp_q       <= '0;
      jrp_q       <= '0;
      rwp_q       <= '0;
      rrp_q       <= '0;
      sdata_out_q <= '0;
      dp_start_q  <= 1'b0;
      dp_a1_q     <= '0;
      dp_a2_q     <= '0;
      job_count_q <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      tmo_q       <= 1'b0;
      wait_cnt_q  <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      swr_q       <= swr_d;
      srd_q       <= srd_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      jwp_q       <= jwp_d;
      jrp_q       <= jrp_d;
      rwp_q       <= rwp_d;
      rrp_q       <= rrp_d;
      sdata_out_q <= sdata_out_d;
      dp_start_q  <= dp_start_d;
      dp_a1_q     <= dp_a1_d;
      dp_a2_q     <= dp_a2_d;
      job_count_q <= job_count_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      tmo_q       <= tmo_d;
      wait_cnt_q  <= wait_cnt_d;
      hold_q      <= hold_d;
    end
  end

  // FIFO storage carries no reset; empty-state reads are masked above
  always_ff @(posedge clk) begin
    if (job_push) job_mem[jwp_q[AW-1:0]] <= {a1_q, a2_q};
  end

  always_ff @(posedge clk) begin
    if (res_push) res_mem[rwp_q[AW-1:0]] <= hold_q;
  end

  assign sdata_out = sdata_out_q;
  assign dp_start  = dp_start_q;
  assign dp_a1     = dp_a1_q;
  assign dp_a2     = dp_a2_q;
  assign job_count = job_count_q;
  assign irq       = ~res_empty | ovf_q | unf_q | tmo_q;

endmodule

// File: tb/tb_mult_job_scheduler.sv
// Randomized scoreboard bench for mult_job_scheduler with a queue-level reference model.
`timescale 1ns/1ps
module tb_mult_job_scheduler;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [15:0] saddress = 16'h0;
  logic        srd = 1'b0;
  logic        swr = 1'b0;
  logic [31:0] sdata_in = 32'h0;
  logic [31:0] sdata_out;
  logic        dp_start;
  logic [23:0] dp_a1, dp_a2;
  logic        dp_busy = 1'b0;
  logic        dp_done;
  logic [31:0] dp_w = 32'h0;
  logic [23:0] dp_l = 24'h0;
  logic        dp_valid = 1'b0;
  logic [15:0] job_count;
  logic        irq;
  logic        rsp_done = 1'b0;
  logic        late_done = 1'b0;

  assign dp_done = rsp_done | late_done;

  mult_job_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .n_reset(n_reset), .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_in(sdata_in), .sdata_out(sdata_out), .dp_start(dp_start),
    .dp_a1(dp_a1), .dp_a2(dp_a2), .dp_busy(dp_busy), .dp_done(dp_done),
    .dp_w(dp_w), .dp_l(dp_l), .dp_valid(dp_valid), .job_count(job_count), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [23:0] a1; logic [23:0] a2; } pair_t;
  typedef struct packed { logic t; logic v; logic [23:0] l; logic [31:0] w; } res_t;

  int total = 0;
  int bad = 0;

  pair_t       exp_issue[$];
  res_t        res_pend[$];
  res_t        m_res[$];
  logic [31:0] rd_exp[$];
  string       rd_name[$];
  logic [23:0] m_a1 = 0, m_a2 = 0;
  int          m_pending = 0;
  bit          m_ovf = 0, m_unf = 0, m_tmo = 0;
  logic [15:0] m_count = 0;
  bit          dp_mute = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  function automatic res_t model_result(logic [23:0] a, logic [23:0] b);
    logic [47:0] p;
    res_t r;
    p   = {24'h0, a} * {24'h0, b};
    r.t = 1'b0;
    r.v = (p[47:32] == 16'h0);
    r.w = p[31:0];
    r.l = 24'($countones(p[31:0]));
    return r;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'h0;
    s[1] = (m_pending == DEPTH);
    s[2] = (m_res.size() != 0);
    s[3] = m_ovf;
    s[4] = m_unf;
    s[5] = m_tmo;
    s[11:8]  = 4'(m_pending);
    s[15:12] = 4'(m_res.size());
    if (m_res.size() != 0) begin
      s[16] = m_res[0].v;
      s[17] = m_res[0].t;
    end
    return s;
  endfunction

  function automatic logic [23:0] rand24();
    case ($urandom_range(0, 3))
      0:       return 24'($urandom_range(0, 255));
      1:       return 24'($urandom_range(0, 65535));
      2:       return 24'($urandom);
      default: return ($urandom_range(0, 1) != 0) ? 24'hFFFFFF : 24'h0;
    endcase
  endfunction

  task automatic host_write(logic [15:0] a, logic [31:0] d);
    case (a)
      16'h0380: m_a1 = d[23:0];
      16'h0388: m_a2 = d[23:0];
      16'h03A0: begin
        if (d[31]) begin
          m_ovf = 0; m_unf = 0; m_tmo = 0;
        end else if (m_pending == DEPTH) begin
          m_ovf = 1;
        end else begin
          res_t r;
          m_pending++;
          exp_issue.push_back({m_a1, m_a2});
          r = '0;
          if (dp_mute) r.t = 1'b1;
          else r = model_result(m_a1, m_a2);
          res_pend.push_back(r);
        end
      end
      default: ;
    endcase
    @(posedge clk); #1;
    saddress = a; sdata_in = d; swr = 1'b1;
    @(posedge clk); #1;
    swr = 1'b0;
  endtask

  task automatic push_job(logic [23:0] a, logic [23:0] b);
    host_write(16'h0380, {8'($urandom), a});
    host_write(16'h0388, {8'($urandom), b});
    host_write(16'h03A0, $urandom & 32'h7FFF_FFFF);
  endtask

  task automatic host_read(logic [15:0] a, string name);
    logic [31:0] e;
    res_t r;
    case (a)
      16'h0390: begin
        if (m_res.size() == 0) begin
          e = 32'h0; m_unf = 1;
        end else begin
          r = m_res.pop_front(); e = r.w;
        end
      end
      16'h0398: e = (m_res.size() != 0) ? {8'h0, m_res[0].l} : 32'h0;
      16'h03A0: e = m_status();
      default:  e = 32'h0;
    endcase
    rd_exp.push_back(e);
    rd_name.push_back(name);
    @(posedge clk); #1;
    saddress = a; srd = 1'b1;
    @(posedge clk); #1;
    srd = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    logic [15:0] target;
    n = 0;
    target = m_count + 16'(res_pend.size());
    while (job_count !== target && n < 300) begin
      @(negedge clk); n++;
    end
    repeat (2) @(negedge clk);
    check("job_count", {16'h0, job_count}, {16'h0, target});
    while (res_pend.size() != 0) begin
      res_t r;
      r = res_pend.pop_front();
      if (r.t) m_tmo = 1;
      m_res.push_back(r);
    end
    m_count = target;
    m_pending = 0;
  endtask

  task automatic check_irq(string name);
    check(name, {31'h0, irq}, {31'h0, (m_res.size() != 0) || m_ovf || m_unf || m_tmo});
  endtask

  task automatic drain(bit with_l);
    int n;
    n = m_res.size();
    for (int i = 0; i < n; i++) begin
      if (with_l) host_read(16'h0398, "read_L");
      host_read(16'h0390, "read_W");
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_sdata_out", sdata_out, 32'h0);
    check("rst_dp_start", {31'h0, dp_start}, 32'h0);
    check("rst_dp_a1", {8'h0, dp_a1}, 32'h0);
    check("rst_dp_a2", {8'h0, dp_a2}, 32'h0);
    check("rst_job_count", {16'h0, job_count}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
  endtask

  // Read-response monitor: sdata_out is valid the cycle after a detected srd edge
  logic srd_prev_tb = 1'b0;
  logic rd_vld_tb = 1'b0;
  always @(posedge clk) begin
    rd_vld_tb   <= srd & ~srd_prev_tb;
    srd_prev_tb <= srd;
  end

  initial forever begin
    @(negedge clk);
    if (rd_vld_tb) begin
      if (rd_exp.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected: got %08h want no read response", sdata_out);
      end else begin
        check(rd_name.pop_front(), sdata_out, rd_exp.pop_front());
      end
    end
  end

  // Issue monitor: every dp_start must match the next accepted job in order
  initial forever begin
    @(negedge clk);
    if (dp_start === 1'b1) begin
      if (exp_issue.size() == 0) begin
        total++; bad++;
        $display("FAIL issue_unexpected: got a1=%06h a2=%06h want none", dp_a1, dp_a2);
      end else begin
        pair_t p;
        p = exp_issue.pop_front();
        check("issue_a1", {8'h0, dp_a1}, {8'h0, p.a1});
        check("issue_a2", {8'h0, dp_a2}, {8'h0, p.a2});
      end
    end
  end

  // Datapath stand-in: answers each dp_start after 1..5 cycles unless muted
  initial forever begin
    @(negedge clk);
    if (dp_start === 1'b1 && !dp_mute) begin
      logic [47:0] p;
      int d;
      p = {24'h0, dp_a1} * {24'h0, dp_a2};
      d = $urandom_range(1, 5);
      repeat (d) @(negedge clk);
      dp_w = p[31:0];
      dp_l = 24'($countones(p[31:0]));
      dp_valid = (p[47:32] == 16'h0);
      rsp_done = 1'b1;
      @(negedge clk);
      rsp_done = 1'b0;
      dp_w = $urandom;
      dp_l = 24'($urandom);
      dp_valid = 1'($urandom);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    n_reset = 1'b1;
    repeat (2) @(negedge clk);

    // Directed 3*5
    push_job(24'd3, 24'd5);
    wait_idle();
    host_read(16'h0398, "dir_L");
    check_irq("dir_irq_before_pop");
    host_read(16'h0390, "dir_W");
    check_irq("dir_irq_after_pop");

    // Overflow while datapath busy
    dp_busy = 1'b1;
    for (int i = 0; i < 5; i++) push_job(rand24(), rand24());
    host_read(16'h03A0, "ovf_status");
    check_irq("ovf_irq");
    host_write(16'h03A0, 32'h8000_0000);
    host_read(16'h03A0, "ovf_cleared_status");
    dp_busy = 1'b0;
    wait_idle();
    host_read(16'h03A0, "full_result_status");
    drain(1'b1);

    // All-ones operands (overflowing product) plus two more, order preserved
    push_job(24'hFFFFFF, 24'hFFFFFF);
    push_job(rand24(), rand24());
    push_job(rand24(), rand24());
    wait_idle();
    host_read(16'h03A0, "ones_status");
    drain(1'b1);

    // Random batches
    for (int b = 0; b < 8; b++) begin
      n = $urandom_range(1, DEPTH);
      for (int j = 0; j < n; j++) push_job(rand24(), rand24());
      wait_idle();
      if ($urandom_range(0, 1) != 0) host_read(16'h03A0, "rand_status");
      drain(1'($urandom_range(0, 1)));
      check_irq("rand_irq");
    end

    // Timeout: datapath never answers
    dp_mute = 1;
    push_job(24'd7, 24'd9);
    wait_idle();
    host_read(16'h03A0, "tmo_status");
    host_read(16'h0390, "tmo_W");
    dp_mute = 0;

    // Underflow
    host_read(16'h0390, "unf_W");
    host_read(16'h03A0, "unf_status");
    check_irq("unf_irq");
    host_write(16'h03A0, 32'h8000_0000);
    host_read(16'h03A0, "clear_status");

    // Reset in the middle of WAIT, then a stale dp_done
    dp_mute = 1;
    push_job(24'd11, 24'd13);
    n = 0;
    while (dp_start !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    repeat (4) @(negedge clk);
    n_reset = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    res_pend.delete(); m_res.delete();
    m_pending = 0; m_count = 0; m_ovf = 0; m_unf = 0; m_tmo = 0; m_a1 = 0; m_a2 = 0;
    @(negedge clk);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);
    late_done = 1'b1; dp_w = 32'hDEAD_BEEF; dp_l = 24'd5; dp_valid = 1'b1;
    @(negedge clk);
    late_done = 1'b0;
    repeat (5) @(negedge clk);
    check("late_done_job_count", {16'h0, job_count}, 32'h0);
    host_read(16'h03A0, "late_done_status");
    check_irq("late_done_irq");
    dp_mute = 0;

    // A fresh job still flows after the reset
    push_job(rand24(), rand24());
    wait_idle();
    drain(1'b1);

    repeat (3) @(negedge clk);
    check("issue_queue_drained", exp_issue.size(), 32'h0);
    check("read_queue_drained", rd_exp.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
